// File: rtl/pred_pkg.sv
// Shared types and constants for the prediction-accuracy scoreboard.
//   sb_state_t : scoreboard FSM state (value 3 is illegal and recovers to SB_WARMUP)
//   STREAK_W   : width of the miss-streak outputs
package pred_pkg;

  typedef enum logic [1:0] {
    SB_WARMUP = 2'd0,
    SB_TRACK  = 2'd1,
    SB_ALARM  = 2'd2
  } sb_state_t;

  localparam int unsigned STREAK_W = 8;

endpackage

// File: rtl/pred_hit_window.sv
// Sliding-window hit tracker: a WINDOW-bit history shift register, a fill counter
// saturating at WINDOW, and a running count of hits held in the history.
// Ports:
//   clk, reset (async, active-high), clear (sync)
//   shift_en         : accept hit_in this cycle
//   hit_in           : 1 = prediction matched
//   fill_full        : registered, history holds WINDOW samples
//   window_hits      : registered hit count over the filled part of the history
//   fill_full_next   : value fill_full takes after this cycle (for same-cycle decisions)
//   window_hits_next : value window_hits takes after this cycle
module pred_hit_window #(
  parameter int unsigned WINDOW = 16,
  localparam int unsigned WH_W = $clog2(WINDOW) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            shift_en,
  input  logic            hit_in,
  output logic            fill_full,
  output logic [WH_W-1:0] window_hits,
  output logic            fill_full_next,
  output logic [WH_W-1:0] window_hits_next
);

  localparam logic [WH_W-1:0] FullCnt = WH_W'(WINDOW);

  logic [WINDOW-1:0] r_hist;
  logic [WINDOW-1:0] w_hist_next;
  logic [WH_W-1:0]   r_fill;
  logic [WH_W-1:0]   w_fill_next;
  logic [WH_W-1:0]   r_hits;
  logic [WH_W-1:0]   w_hits_next;
  logic              w_oldest;

  // History resets to zero, so the bit falling out is 0 until the window has filled.
  assign w_oldest = r_hist[WINDOW-1];

  always_comb begin
    w_hist_next = r_hist;
    w_fill_next = r_fill;
    w_hits_next = r_hits;
    if (shift_en) begin
      w_hist_next = {r_hist[WINDOW-2:0], hit_in};
      w_hits_next = r_hits + WH_W'(hit_in) - WH_W'(w_oldest);
      if (r_fill != FullCnt) begin
        w_fill_next = r_fill + WH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist <= '0;
      r_fill <= '0;
      r_hits <= '0;
    end else if (clear) begin
      r_hist <= '0;
      r_fill <= '0;
      r_hits <= '0;
    end else begin
      r_hist <= w_hist_next;
      r_fill <= w_fill_next;
      r_hits <= w_hits_next;
    end
  end

  assign fill_full        = (r_fill == FullCnt);
  assign window_hits      = r_hits;
  assign fill_full_next   = (w_fill_next == FullCnt);
  assign window_hits_next = w_hits_next;

endmodule

// File: rtl/pred_accuracy_scoreboard.sv
// Prediction-accuracy scoreboard. Consumes one predicted/actual bit pair per valid
// sample, keeps saturating lifetime totals, a sliding-window hit count, a miss streak,
// and a WARMUP/TRACK/ALARM FSM with hysteresis on window misses.
// Optional feature macro: PRED_SCOREBOARD_MAXSTREAK_EN (builds the max_streak tracker;
// otherwise max_streak is tied to zero).
// Ports:
//   clk, reset (async, active-high), clear (sync, wins over sample_valid)
//   sample_valid, predicted_bit, actual_bit : sample input
//   total_cnt, hit_cnt : saturating lifetime counts
//   window_hits        : hits among the last min(fill, WINDOW) samples
//   state, alarm       : FSM state and registered alarm flag
//   miss_streak        : current consecutive-miss run (saturating)
//   max_streak         : longest miss run since reset/clear
// All outputs are registered; a sample shows on the outputs one cycle later.
module pred_accuracy_scoreboard
  import pred_pkg::*;
#(
  parameter int unsigned WINDOW    = 16,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned ALARM_SET = 4,
  parameter int unsigned ALARM_CLR = 1,
  localparam int unsigned WH_W = $clog2(WINDOW) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                sample_valid,
  input  logic                predicted_bit,
  input  logic                actual_bit,
  output logic [CNT_W-1:0]    total_cnt,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [WH_W-1:0]     window_hits,
  output sb_state_t           state,
  output logic                alarm,
  output logic [STREAK_W-1:0] miss_streak,
  output logic [STREAK_W-1:0] max_streak
);

  localparam logic [WH_W-1:0] SetTh  = WH_W'(ALARM_SET);
  localparam logic [WH_W-1:0] ClrTh  = WH_W'(ALARM_CLR);
  localparam logic [WH_W-1:0] WinCnt = WH_W'(WINDOW);

  logic                w_sample;
  logic                w_hit;
  logic                w_fill_full;
  logic                w_fill_full_next;
  logic [WH_W-1:0]     w_hits_next;
  logic [WH_W-1:0]     w_misses_next;
  logic [STREAK_W-1:0] w_streak_next;

  logic [CNT_W-1:0]    r_total;
  logic [CNT_W-1:0]    r_hit_total;
  logic [STREAK_W-1:0] r_streak;
  sb_state_t           r_state;
  logic                r_alarm;

  // A clear in the same cycle drops the sample.
  assign w_sample = sample_valid & ~clear;
  assign w_hit    = ~(predicted_bit ^ actual_bit);

  pred_hit_window #(
    .WINDOW (WINDOW)
  ) u_hit_window (
    .clk              (clk),
    .reset            (reset),
    .clear            (clear),
    .shift_en         (w_sample),
    .hit_in           (w_hit),
    .fill_full        (w_fill_full),
    .window_hits      (window_hits),
    .fill_full_next   (w_fill_full_next),
    .window_hits_next (w_hits_next)
  );

  // Only consulted outside WARMUP, where fill is pinned at WINDOW.
  assign w_misses_next = WinCnt - w_hits_next;

  always_comb begin
    w_streak_next = r_streak;
    if (w_sample) begin
      if (w_hit) begin
        w_streak_next = '0;
      end else if (r_streak != '1) begin
        w_streak_next = r_streak + STREAK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_total     <= '0;
      r_hit_total <= '0;
      r_streak    <= '0;
    end else if (clear) begin
      r_total     <= '0;
      r_hit_total <= '0;
      r_streak    <= '0;
    end else begin
      r_streak <= w_streak_next;
      if (w_sample && (r_total != '1)) begin
        r_total <= r_total + CNT_W'(1);
      end
      if (w_sample && w_hit && (r_hit_total != '1)) begin
        r_hit_total <= r_hit_total + CNT_W'(1);
      end
    end
  end

  // FSM evaluated on the post-update window counts of the accepted sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SB_WARMUP;
      r_alarm <= 1'b0;
    end else if (clear) begin
      r_state <= SB_WARMUP;
      r_alarm <= 1'b0;
    end else begin
      case (r_state)
        SB_WARMUP: begin
          if (w_sample && !w_fill_full && w_fill_full_next) begin
            r_state <= SB_TRACK;
          end
        end
        SB_TRACK: begin
          if (w_sample && (w_misses_next >= SetTh)) begin
            r_state <= SB_ALARM;
            r_alarm <= 1'b1;
          end
        end
        SB_ALARM: begin
          if (w_sample && (w_misses_next <= ClrTh)) begin
            r_state <= SB_TRACK;
            r_alarm <= 1'b0;
          end
        end
        default: begin
          r_state <= SB_WARMUP;
          r_alarm <= 1'b0;
        end
      endcase
    end
  end

`ifdef PRED_SCOREBOARD_MAXSTREAK_EN
  logic [STREAK_W-1:0] r_max_streak;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_max_streak <= '0;
    end else if (clear) begin
      r_max_streak <= '0;
    end else if (w_sample && (w_streak_next > r_max_streak)) begin
      r_max_streak <= w_streak_next;
    end
  end

  assign max_streak = r_max_streak;
`else
  assign max_streak = '0;
`endif

  assign total_cnt   = r_total;
  assign hit_cnt     = r_hit_total;
  assign state       = r_state;
  assign alarm       = r_alarm;
  assign miss_streak = r_streak;

endmodule

// File: tb/tb_pred_accuracy_scoreboard.sv
// Directed bench for pred_accuracy_scoreboard: a default instance plus a CNT_W=4
// instance sharing the same stimulus for counter saturation.
module tb_pred_accuracy_scoreboard;
  import pred_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic sample_valid = 1'b0;
  logic predicted_bit = 1'b0;
  logic actual_bit = 1'b0;

  logic [15:0] total_cnt, hit_cnt;
  logic [4:0]  window_hits;
  sb_state_t   state;
  logic        alarm;
  logic [7:0]  miss_streak, max_streak;

  logic [3:0]  total4, hit4;
  logic [4:0]  wh4;
  sb_state_t   state4;
  logic        alarm4;
  logic [7:0]  streak4, max4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pred_accuracy_scoreboard u_dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .sample_valid  (sample_valid),
    .predicted_bit (predicted_bit),
    .actual_bit    (actual_bit),
    .total_cnt     (total_cnt),
    .hit_cnt       (hit_cnt),
    .window_hits   (window_hits),
    .state         (state),
    .alarm         (alarm),
    .miss_streak   (miss_streak),
    .max_streak    (max_streak)
  );

  pred_accuracy_scoreboard #(
    .CNT_W (4)
  ) u_dut4 (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .sample_valid  (sample_valid),
    .predicted_bit (predicted_bit),
    .actual_bit    (actual_bit),
    .total_cnt     (total4),
    .hit_cnt       (hit4),
    .window_hits   (wh4),
    .state         (state4),
    .alarm         (alarm4),
    .miss_streak   (streak4),
    .max_streak    (max4)
  );

  // One sample; outputs are observed #1 after the capturing edge.
  task automatic send(input logic p, input logic a);
    @(negedge clk);
    sample_valid  = 1'b1;
    predicted_bit = p;
    actual_bit    = a;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (total_cnt !== 16'd0) begin failures++; $display("FAIL reset_total got=%0d exp=0", total_cnt); end
    checks++; if (hit_cnt !== 16'd0) begin failures++; $display("FAIL reset_hit got=%0d exp=0", hit_cnt); end
    checks++; if (window_hits !== 5'd0) begin failures++; $display("FAIL reset_wh got=%0d exp=0", window_hits); end
    checks++; if (state !== SB_WARMUP) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL reset_alarm got=%0b exp=0", alarm); end
    checks++; if (miss_streak !== 8'd0) begin failures++; $display("FAIL reset_streak got=%0d exp=0", miss_streak); end
    checks++; if (max_streak !== 8'd0) begin failures++; $display("FAIL reset_max got=%0d exp=0", max_streak); end
  endtask

  task automatic test_warmup;
    for (int i = 0; i < 16; i++) begin
      send(1'b1, 1'b1);
      if (i == 14) begin
        checks++; if (state !== SB_WARMUP) begin failures++; $display("FAIL warm15_state got=%0d exp=0", state); end
      end
    end
    checks++; if (state !== SB_TRACK) begin failures++; $display("FAIL warm_state got=%0d exp=1", state); end
    checks++; if (window_hits !== 5'd16) begin failures++; $display("FAIL warm_wh got=%0d exp=16", window_hits); end
    checks++; if (total_cnt !== 16'd16) begin failures++; $display("FAIL warm_total got=%0d exp=16", total_cnt); end
    checks++; if (hit_cnt !== 16'd16) begin failures++; $display("FAIL warm_hit got=%0d exp=16", hit_cnt); end
    checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL warm_alarm got=%0b exp=0", alarm); end
  endtask

  task automatic test_alarm;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 1'b0);
      if (i == 2) begin
        checks++; if (state !== SB_TRACK) begin failures++; $display("FAIL alarm3_state got=%0d exp=1", state); end
      end
    end
    checks++; if (window_hits !== 5'd12) begin failures++; $display("FAIL alarm_wh got=%0d exp=12", window_hits); end
    checks++; if (state !== SB_ALARM) begin failures++; $display("FAIL alarm_state got=%0d exp=2", state); end
    checks++; if (alarm !== 1'b1) begin failures++; $display("FAIL alarm_flag got=%0b exp=1", alarm); end
    checks++; if (miss_streak !== 8'd4) begin failures++; $display("FAIL alarm_streak got=%0d exp=4", miss_streak); end
    checks++; if (hit_cnt !== 16'd16) begin failures++; $display("FAIL alarm_hit got=%0d exp=16", hit_cnt); end
  endtask

  task automatic test_recover;
    for (int i = 0; i < 16; i++) begin
      send(1'b0, 1'b0);
      if (i == 13) begin
        checks++; if (state !== SB_ALARM) begin failures++; $display("FAIL rec14_state got=%0d exp=2", state); end
      end
      if (i == 14) begin
        checks++; if (state !== SB_TRACK) begin failures++; $display("FAIL rec15_state got=%0d exp=1", state); end
        checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL rec15_alarm got=%0b exp=0", alarm); end
      end
    end
    checks++; if (window_hits !== 5'd16) begin failures++; $display("FAIL rec_wh got=%0d exp=16", window_hits); end
    checks++; if (miss_streak !== 8'd0) begin failures++; $display("FAIL rec_streak got=%0d exp=0", miss_streak); end
    // Idle cycles must hold everything.
    repeat (3) @(posedge clk);
    #1;
    checks++; if (total_cnt !== 16'd36) begin failures++; $display("FAIL idle_total got=%0d exp=36", total_cnt); end
    checks++; if (state !== SB_TRACK) begin failures++; $display("FAIL idle_state got=%0d exp=1", state); end
  endtask

  task automatic test_saturate_clear;
    for (int i = 0; i < 20; i++) send(1'b1, 1'b1);
    checks++; if (total4 !== 4'd15) begin failures++; $display("FAIL sat_total4 got=%0d exp=15", total4); end
    checks++; if (hit4 !== 4'd15) begin failures++; $display("FAIL sat_hit4 got=%0d exp=15", hit4); end
    checks++; if (total_cnt !== 16'd56) begin failures++; $display("FAIL sat_total got=%0d exp=56", total_cnt); end
    checks++; if (hit_cnt !== 16'd52) begin failures++; $display("FAIL sat_hit got=%0d exp=52", hit_cnt); end
    @(negedge clk);
    clear = 1'b1;
    sample_valid = 1'b1;
    predicted_bit = 1'b1;
    actual_bit = 1'b0;
    @(posedge clk);
    #1;
    clear = 1'b0;
    sample_valid = 1'b0;
    checks++; if (total4 !== 4'd0) begin failures++; $display("FAIL clr_total4 got=%0d exp=0", total4); end
    checks++; if (total_cnt !== 16'd0) begin failures++; $display("FAIL clr_total got=%0d exp=0", total_cnt); end
    checks++; if (window_hits !== 5'd0) begin failures++; $display("FAIL clr_wh got=%0d exp=0", window_hits); end
    checks++; if (state !== SB_WARMUP) begin failures++; $display("FAIL clr_state got=%0d exp=0", state); end
    checks++; if (miss_streak !== 8'd0) begin failures++; $display("FAIL clr_streak got=%0d exp=0", miss_streak); end
  endtask

  task automatic test_max_streak;
    logic [7:0] exp_max;
`ifdef PRED_SCOREBOARD_MAXSTREAK_EN
    exp_max = 8'd5;
`else
    exp_max = 8'd0;
`endif
    for (int i = 0; i < 5; i++) send(1'b0, 1'b1);
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b0, 1'b1);
    checks++; if (miss_streak !== 8'd2) begin failures++; $display("FAIL ms_streak got=%0d exp=2", miss_streak); end
    checks++; if (max_streak !== exp_max) begin failures++; $display("FAIL ms_max got=%0d exp=%0d", max_streak, exp_max); end
    checks++; if (total_cnt !== 16'd8) begin failures++; $display("FAIL ms_total got=%0d exp=8", total_cnt); end
    checks++; if (hit_cnt !== 16'd1) begin failures++; $display("FAIL ms_hit got=%0d exp=1", hit_cnt); end
    checks++; if (window_hits !== 5'd1) begin failures++; $display("FAIL ms_wh got=%0d exp=1", window_hits); end
    checks++; if (state !== SB_WARMUP) begin failures++; $display("FAIL ms_state got=%0d exp=0", state); end
  endtask

  task automatic test_reset_midstream;
    send(1'b1, 1'b1);
    send(1'b1, 1'b1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (total_cnt !== 16'd0) begin failures++; $display("FAIL mid_total got=%0d exp=0", total_cnt); end
    checks++; if (window_hits !== 5'd0) begin failures++; $display("FAIL mid_wh got=%0d exp=0", window_hits); end
    checks++; if (miss_streak !== 8'd0) begin failures++; $display("FAIL mid_streak got=%0d exp=0", miss_streak); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_alarm();
    test_recover();
    test_saturate_clear();
    test_max_streak();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
